// File: rtl/data_mem_ctrl.sv
// -----------------------------------------------------------------------------
// data_mem_ctrl
//   RV32I data-memory controller. A word-organised RAM of 2**ADDR_WIDTH words
//   with one request port and one response port, each a valid/ready channel.
//   Handles LB/LH/LW/LBU/LHU and SB/SH/SW, with byte-lane writes and sign/zero
//   extension on loads. Misaligned, out-of-range and illegal-funct3 accesses
//   return rsp_err=1 with rsp_rdata=0 and never touch memory.
//
//   Handshake rule (both channels): a transfer happens on a rising clk edge
//   where valid and ready are both high. A producer that raises valid keeps
//   it and its payload stable until that edge. req_ready is a function of
//   state only, and rsp_valid never looks at rsp_ready.
//
// Parameters
//   ADDR_WIDTH  word-address bits (byte range 0 .. 4*2**ADDR_WIDTH-1)
//   LATENCY     cycles from request acceptance to rsp_valid, 1..4
//
// Ports
//   clk, reset_n            clock, asynchronous active-low reset
//   req_valid/req_ready     request handshake
//   req_we, req_funct3      1=store / 0=load, RV32I funct3
//   req_addr, req_wdata     byte address, right-aligned store data
//   rsp_valid/rsp_ready     response handshake
//   rsp_rdata, rsp_err      extended load data (0 for stores/errors), fault
//   dbg_state               current FSM state (0=IDLE, 1=WAIT, 2=RESP)
// -----------------------------------------------------------------------------
module data_mem_ctrl #(
   parameter int ADDR_WIDTH = 6,
   parameter int LATENCY    = 1
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [2:0]  req_funct3,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err,
   output logic [1:0]  dbg_state
);

   localparam int DEPTH = 1 << ADDR_WIDTH;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_RESP = 2'd2
   } state_t;

   state_t      state_q, state_d;
   logic [2:0]  cnt_q, cnt_d;
   logic [31:0] rdata_q;
   logic        err_q;

   // Storage has no reset: contents survive reset_n.
   logic [31:0] mem [DEPTH];

   logic                  accept;
   logic                  f3_legal;
   logic                  misaligned;
   logic                  out_of_range;
   logic                  acc_err;
   logic [ADDR_WIDTH-1:0] word_idx;
   logic [31:0]           rd_word;
   logic [15:0]           ld_half;
   logic [31:0]           ld_data;
   logic [31:0]           wr_data;
   logic [3:0]            wr_be;
   logic                  mem_we;

   assign accept   = (state_q == S_IDLE) && req_valid;
   assign word_idx = req_addr[ADDR_WIDTH+1:2];
   assign rd_word  = mem[word_idx];

   // Access decode: legality, alignment and range.
   always_comb begin
      f3_legal     = 1'b0;
      misaligned   = 1'b0;
      out_of_range = |req_addr[31:ADDR_WIDTH+2];
      if (req_we) begin
         f3_legal = (req_funct3 == 3'b000) || (req_funct3 == 3'b001) ||
                    (req_funct3 == 3'b010);
      end else begin
         f3_legal = (req_funct3 == 3'b000) || (req_funct3 == 3'b001) ||
                    (req_funct3 == 3'b010) || (req_funct3 == 3'b100) ||
                    (req_funct3 == 3'b101);
      end
      case (req_funct3[1:0])
         2'b01:   misaligned = req_addr[0];
         2'b10:   misaligned = |req_addr[1:0];
         default: misaligned = 1'b0;
      endcase
      acc_err = !f3_legal || misaligned || out_of_range;
   end

   // Load path: shift the addressed byte/half down to bit 0, then extend.
   always_comb begin
      ld_half = 16'(rd_word >> {req_addr[1:0], 3'b000});
      case (req_funct3)
         3'b000:  ld_data = {{24{ld_half[7]}}, ld_half[7:0]};
         3'b001:  ld_data = {{16{ld_half[15]}}, ld_half};
         3'b010:  ld_data = rd_word;
         3'b100:  ld_data = {24'd0, ld_half[7:0]};
         3'b101:  ld_data = {16'd0, ld_half};
         default: ld_data = 32'd0;
      endcase
   end

   // Store path: replicate the data across lanes, enable only the target lanes.
   always_comb begin
      case (req_funct3[1:0])
         2'b00: begin
            wr_data = {4{req_wdata[7:0]}};
            wr_be   = 4'b0001 << req_addr[1:0];
         end
         2'b01: begin
            wr_data = {2{req_wdata[15:0]}};
            wr_be   = req_addr[1] ? 4'b1100 : 4'b0011;
         end
         default: begin
            wr_data = req_wdata;
            wr_be   = 4'b1111;
         end
      endcase
      mem_we = accept && req_we && !acc_err;
   end

   always_ff @(posedge clk) begin
      if (mem_we) begin
         for (int i = 0; i < 4; i++) begin
            if (wr_be[i]) begin
               mem[word_idx][8*i +: 8] <= wr_data[8*i +: 8];
            end
         end
      end
   end

   // State register plus the latched response payload.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= S_IDLE;
         cnt_q   <= 3'd0;
         rdata_q <= 32'd0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         if (accept) begin
            rdata_q <= (acc_err || req_we) ? 32'd0 : ld_data;
            err_q   <= acc_err;
         end
      end
   end

   // Next-state logic. WAIT counts cnt down; leaving at cnt==1 puts rsp_valid
   // exactly LATENCY cycles after the accepting edge.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         S_IDLE: begin
            if (req_valid) begin
               if (LATENCY <= 1) begin
                  state_d = S_RESP;
                  cnt_d   = 3'd0;
               end else begin
                  state_d = S_WAIT;
                  cnt_d   = 3'(LATENCY - 1);
               end
            end
         end
         S_WAIT: begin
            if (cnt_q <= 3'd1) begin
               state_d = S_RESP;
               cnt_d   = 3'd0;
            end else begin
               cnt_d = cnt_q - 3'd1;
            end
         end
         S_RESP: begin
            if (rsp_ready) begin
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
            cnt_d   = 3'd0;
         end
      endcase
   end

   assign req_ready = (state_q == S_IDLE);
   assign rsp_valid = (state_q == S_RESP);
   assign rsp_rdata = rdata_q;
   assign rsp_err   = err_q;
   assign dbg_state = state_q;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// -----------------------------------------------------------------------------
// tb_data_mem_ctrl
//   Bench for data_mem_ctrl (ADDR_WIDTH=6, LATENCY=3). A byte-array model
//   derived from the RV32I load/store rules predicts every response; expected
//   responses pass through exp_q. Directed cases cover the listed scenarios,
//   followed by randomized loads/stores with random response backpressure.
// -----------------------------------------------------------------------------
module tb_data_mem_ctrl;

   localparam int AW        = 6;
   localparam int LAT       = 3;
   localparam int NBYTES    = 4 << AW;
   localparam int TIMEOUT   = 20;

   // ---------------- clock / reset ----------------
   logic        clk = 1'b0;
   logic        reset_n;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [2:0]  req_funct3;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_rdata;
   logic        rsp_err;
   logic [1:0]  dbg_state;

   always #5 clk = ~clk;

   data_mem_ctrl #(.ADDR_WIDTH(AW), .LATENCY(LAT)) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_we     (req_we),
      .req_funct3 (req_funct3),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .rsp_valid  (rsp_valid),
      .rsp_ready  (rsp_ready),
      .rsp_rdata  (rsp_rdata),
      .rsp_err    (rsp_err),
      .dbg_state  (dbg_state)
   );

   // ---------------- scoreboard ----------------
   int total = 0;
   int bad   = 0;
   logic [32:0] exp_q[$];       // {err, rdata}
   logic [7:0]  ref_mem [NBYTES];

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=0x%08h exp=0x%08h @%0t", tag, got, exp, $time);
      end
   endtask

   // Reference model: applies an access to the byte array, returns {err, rdata}.
   function automatic logic [32:0] ref_access(input logic we, input logic [2:0] f3,
                                              input logic [31:0] addr, input logic [31:0] wd);
      int size;
      bit legal;
      logic [31:0] val;
      int base;
      if (we) legal = (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2);
      else    legal = (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2) || (f3 == 3'd4) || (f3 == 3'd5);
      if (!legal) return {1'b1, 32'd0};
      size = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
      if (addr >= 32'(NBYTES)) return {1'b1, 32'd0};
      if ((addr % 32'(size)) != 0) return {1'b1, 32'd0};
      base = int'(addr);
      if (we) begin
         for (int b = 0; b < size; b++) ref_mem[base + b] = wd[8*b +: 8];
         return {1'b0, 32'd0};
      end
      val = 32'd0;
      for (int b = 0; b < size; b++) val = val | (32'(ref_mem[base + b]) << (8 * b));
      if (!f3[2] && size < 4 && val[8*size-1]) val = val | (32'hFFFF_FFFF << (8 * size));
      return {1'b0, val};
   endfunction

   // ---------------- driver ----------------
   // One full transaction: issue, measure latency, hold off rsp_ready for
   // 'hold' cycles checking stability, then complete the handshake.
   task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wd, input int hold,
                         output logic [31:0] got_data, output logic got_err);
      logic [32:0] exp;
      int cyc;
      exp_q.push_back(ref_access(we, f3, addr, wd));
      @(negedge clk);
      check_eq("req_ready_idle", {31'd0, req_ready}, 32'd1);
      req_valid  = 1'b1;
      req_we     = we;
      req_funct3 = f3;
      req_addr   = addr;
      req_wdata  = wd;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      cyc = 0;
      do begin
         @(negedge clk);
         cyc++;
         if (cyc == 1) check_eq("req_ready_busy", {31'd0, req_ready}, 32'd0);
      end while (!rsp_valid && cyc < TIMEOUT);
      check_eq("latency", 32'(cyc), 32'(LAT));
      exp = exp_q.pop_front();
      got_data = rsp_rdata;
      got_err  = rsp_err;
      check_eq("rsp_rdata", rsp_rdata, exp[31:0]);
      check_eq("rsp_err", {31'd0, rsp_err}, {31'd0, exp[32]});
      for (int h = 0; h < hold; h++) begin
         @(negedge clk);
         check_eq("hold_valid", {31'd0, rsp_valid}, 32'd1);
         check_eq("hold_rdata", rsp_rdata, exp[31:0]);
         check_eq("hold_err", {31'd0, rsp_err}, {31'd0, exp[32]});
      end
      rsp_ready = 1'b1;
      @(posedge clk);
      #1;
      rsp_ready = 1'b0;
      @(negedge clk);
      check_eq("req_ready_after", {31'd0, req_ready}, 32'd1);
      check_eq("rsp_valid_after", {31'd0, rsp_valid}, 32'd0);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      logic [31:0] d;
      logic        e;
      logic [2:0]  f3;
      logic [31:0] addr;
      logic        we;
      int          sel;
      int          cyc;

      reset_n    = 1'b0;
      req_valid  = 1'b0;
      req_we     = 1'b0;
      req_funct3 = 3'd0;
      req_addr   = 32'd0;
      req_wdata  = 32'd0;
      rsp_ready  = 1'b0;

      // Reset values
      repeat (3) @(negedge clk);
      check_eq("rst_req_ready", {31'd0, req_ready}, 32'd1);
      check_eq("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
      check_eq("rst_rsp_rdata", rsp_rdata, 32'd0);
      check_eq("rst_rsp_err", {31'd0, rsp_err}, 32'd0);
      check_eq("rst_state", {30'd0, dbg_state}, 32'd0);
      reset_n = 1'b1;
      @(negedge clk);

      // Fill all of memory so the model is fully defined
      for (int i = 0; i < NBYTES / 4; i++) do_req(1'b1, 3'b010, 32'(i * 4), $urandom, 0, d, e);

      // Write then read, sign/zero extension
      do_req(1'b1, 3'b010, 32'h10, 32'h8000_00F1, 0, d, e);
      do_req(1'b0, 3'b000, 32'h10, 32'd0, 0, d, e);
      check_eq("lb_0x10", d, 32'hFFFF_FFF1);
      do_req(1'b0, 3'b100, 32'h10, 32'd0, 0, d, e);
      check_eq("lbu_0x10", d, 32'h0000_00F1);
      do_req(1'b0, 3'b001, 32'h12, 32'd0, 0, d, e);
      check_eq("lh_0x12", d, 32'hFFFF_8000);
      do_req(1'b0, 3'b101, 32'h12, 32'd0, 0, d, e);
      check_eq("lhu_0x12", d, 32'h0000_8000);
      do_req(1'b0, 3'b010, 32'h10, 32'd0, 0, d, e);
      check_eq("lw_0x10", d, 32'h8000_00F1);

      // Lane merge
      do_req(1'b1, 3'b010, 32'h20, 32'h1122_3344, 0, d, e);
      do_req(1'b1, 3'b000, 32'h21, 32'h0000_00AA, 0, d, e);
      do_req(1'b1, 3'b001, 32'h22, 32'h0000_BBCC, 0, d, e);
      do_req(1'b0, 3'b010, 32'h20, 32'd0, 0, d, e);
      check_eq("merge_lw", d, 32'hBBCC_AA44);

      // Faults
      do_req(1'b1, 3'b010, 32'h22, 32'hDEAD_BEEF, 0, d, e);
      check_eq("err_sw_mis", {31'd0, e}, 32'd1);
      do_req(1'b0, 3'b001, 32'h23, 32'd0, 0, d, e);
      check_eq("err_lh_mis", {31'd0, e}, 32'd1);
      check_eq("err_lh_data", d, 32'd0);
      do_req(1'b0, 3'b010, 32'h100, 32'd0, 0, d, e);
      check_eq("err_lw_oor", {31'd0, e}, 32'd1);
      do_req(1'b0, 3'b011, 32'h20, 32'd0, 0, d, e);
      check_eq("err_f3_011", {31'd0, e}, 32'd1);
      do_req(1'b1, 3'b011, 32'h20, 32'hFFFF_FFFF, 0, d, e);
      check_eq("err_st_f3", {31'd0, e}, 32'd1);
      do_req(1'b0, 3'b010, 32'h20, 32'd0, 5, d, e);
      check_eq("after_err_lw", d, 32'hBBCC_AA44);

      // Reset during WAIT of a store
      @(negedge clk);
      req_valid  = 1'b1;
      req_we     = 1'b1;
      req_funct3 = 3'b010;
      req_addr   = 32'h08;
      req_wdata  = 32'h5A5A_5A5A;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      void'(ref_access(1'b1, 3'b010, 32'h08, 32'h5A5A_5A5A));
      @(negedge clk);
      check_eq("wait_state", {30'd0, dbg_state}, 32'd1);
      reset_n = 1'b0;
      #1;
      check_eq("rst_wait_valid", {31'd0, rsp_valid}, 32'd0);
      check_eq("rst_wait_state", {30'd0, dbg_state}, 32'd0);
      @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
      check_eq("rst_wait_ready", {31'd0, req_ready}, 32'd1);
      do_req(1'b0, 3'b010, 32'h08, 32'd0, 0, d, e);
      check_eq("lw_after_rst", d, 32'h5A5A_5A5A);

      // Reset while a response is pending: rsp_valid must fall at once
      @(negedge clk);
      req_valid  = 1'b1;
      req_we     = 1'b0;
      req_funct3 = 3'b010;
      req_addr   = 32'h10;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      cyc = 0;
      do begin
         @(negedge clk);
         cyc++;
      end while (!rsp_valid && cyc < TIMEOUT);
      check_eq("resp_pending", {31'd0, rsp_valid}, 32'd1);
      reset_n = 1'b0;
      #1;
      check_eq("rst_resp_valid", {31'd0, rsp_valid}, 32'd0);
      check_eq("rst_resp_rdata", rsp_rdata, 32'd0);
      @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);

      // Randomized traffic
      for (int n = 0; n < 150; n++) begin
         we  = 1'($urandom_range(0, 1));
         sel = $urandom_range(0, 9);
         if ($urandom_range(0, 7) == 0) f3 = 3'($urandom_range(0, 7));
         else if (we) f3 = 3'($urandom_range(0, 2));
         else begin
            f3 = 3'($urandom_range(0, 4));
            if (f3 == 3'd3) f3 = 3'd5;
         end
         if (sel == 0) addr = $urandom | 32'h0000_0100;
         else begin
            addr = 32'($urandom_range(0, NBYTES - 1));
            if (sel < 8) addr = addr & (f3[1] ? ~32'd3 : (f3[0] ? ~32'd1 : ~32'd0));
         end
         do_req(we, f3, addr, $urandom, $urandom_range(0, 3), d, e);
      end

      check_eq("exp_q_empty", 32'(exp_q.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

endmodule
